// File: rtl/mac_share_arbiter.sv
// Round-robin sharing of one registered multiply-add unit between N_REQ requesters.
// Credit-gated issue, fixed-latency tag pipe and a FWFT result FIFO tagged with requester id.
module mac_share_arbiter #(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned MAC_LATENCY   = 1,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned SIZE_A        = 8,
  parameter int unsigned SIZE_B        = 8,
  parameter int unsigned SIZE_C        = 8,
  parameter int unsigned SIZE_DATA_OUT = 16,
  localparam int unsigned ID_W         = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*SIZE_A-1:0]    req_a,
  input  logic [N_REQ*SIZE_B-1:0]    req_b,
  input  logic [N_REQ*SIZE_C-1:0]    req_c,
  output logic [SIZE_A-1:0]          mac_a,
  output logic [SIZE_B-1:0]          mac_b,
  output logic [SIZE_C-1:0]          mac_c,
  input  logic [SIZE_DATA_OUT-1:0]   mac_result,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [SIZE_DATA_OUT-1:0]   rsp_data,
  output logic [ID_W-1:0]            rsp_id,
  output logic                       busy
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [ID_W-1:0]          rr_q;
  logic [ID_W-1:0]          grant;
  logic [ID_W-1:0]          rr_next;
  logic [ID_W:0]            scan_idx;
  logic                     found;
  logic                     issue;
  logic                     push;
  logic                     pop;
  logic [CW-1:0]            credits_q;
  logic [CW-1:0]            credits_d;
  logic [CW-1:0]            cnt_q;
  logic [CW-1:0]            cnt_d;
  logic [MAC_LATENCY:0]     tag_vld_q;
  logic [MAC_LATENCY:0]     tag_vld_d;
  logic [ID_W-1:0]          tag_id_q [MAC_LATENCY+1];
  logic [SIZE_DATA_OUT-1:0] mem_data_q [FIFO_DEPTH];
  logic [ID_W-1:0]          mem_id_q [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr_q;
  logic [AW-1:0]            rd_ptr_q;

  // Grant: first valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      scan_idx = {1'b0, rr_q} + (ID_W+1)'(i);
      if (scan_idx >= (ID_W+1)'(N_REQ)) scan_idx = scan_idx - (ID_W+1)'(N_REQ);
      if (!found && req_valid[scan_idx[ID_W-1:0]]) begin
        found = 1'b1;
        grant = scan_idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    issue     = found && (credits_q != '0) && !reset;
    req_ready = issue ? (N_REQ'(1) << grant) : '0;
    rr_next   = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + ID_W'(1);
    rsp_valid = (cnt_q != '0);
    pop       = rsp_valid && rsp_ready;
    push      = tag_vld_q[MAC_LATENCY];
    credits_d = credits_q - CW'(issue) + CW'(pop);
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
    tag_vld_d = {tag_vld_q[MAC_LATENCY-1:0], issue};
    rsp_data  = mem_data_q[rd_ptr_q];
    rsp_id    = mem_id_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q      <= '0;
      mac_a     <= '0;
      mac_b     <= '0;
      mac_c     <= '0;
      credits_q <= CW'(FIFO_DEPTH);
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tag_vld_q <= '0;
      busy      <= 1'b0;
      for (int k = 0; k <= int'(MAC_LATENCY); k++) tag_id_q[k] <= '0;
      for (int k = 0; k < int'(FIFO_DEPTH); k++) begin
        mem_data_q[k] <= '0;
        mem_id_q[k]   <= '0;
      end
    end else begin
      if (issue) begin
        rr_q  <= rr_next;
        mac_a <= req_a[int'(grant)*SIZE_A +: SIZE_A];
        mac_b <= req_b[int'(grant)*SIZE_B +: SIZE_B];
        mac_c <= req_c[int'(grant)*SIZE_C +: SIZE_C];
      end
      tag_vld_q   <= tag_vld_d;
      tag_id_q[0] <= grant;
      for (int k = 1; k <= int'(MAC_LATENCY); k++) tag_id_q[k] <= tag_id_q[k-1];
      // Credits guarantee a free slot whenever the tag pipe delivers a result.
      if (push) begin
        mem_data_q[wr_ptr_q] <= mac_result;
        mem_id_q[wr_ptr_q]   <= tag_id_q[MAC_LATENCY];
        wr_ptr_q <= (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      cnt_q     <= cnt_d;
      credits_q <= credits_d;
      busy      <= (|tag_vld_d) || (cnt_d != '0);
    end
  end

endmodule
